dapuf: RTL and testbench

//  Cycle-based behavioural model of a 64-stage Double Arbiter PUF (DAPUF) for simulation and FPGA bring-up.
//  Two delay chains (L, R) share one challenge, and both chains race in parallel.
//  Two cross arbiters compare L against R: one on the top paths, one on the bottom paths.
//  The 1-bit response is the XOR of the two arbiter decisions.
//  The block sits beside the challenge generator; its response feeds the PUF response collector.

---
 rtl/dapuf_pkg.sv | 27 ++
 rtl/dapuf_chain.sv | 61 ++++++
 rtl/dapuf.sv | 175 +++++++++++++++++
 tb/tb_dapuf.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dapuf_pkg.sv
// Shared types and constants for the Double Arbiter PUF model.
// Build option: define DAPUF_NOISE_EN to enable metastable-arbiter noise.
package dapuf_pkg;

    localparam int unsigned ACC_W  = 16;
    localparam int unsigned DLY_W  = 4;
    localparam int unsigned SKEW_W = 8;
    localparam int unsigned LFSR_W = 16;

    // x^16 + x^14 + x^13 + x^11 + 1 : taps on bits 15, 13, 12, 10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {IDLE, EVAL, RESOLVE, REARM} state_t;

    // One LFSR word split into the four per-stage delay nibbles
    typedef struct packed {
        logic [DLY_W-1:0] d_xb;
        logic [DLY_W-1:0] d_xt;
        logic [DLY_W-1:0] d_sb;
        logic [DLY_W-1:0] d_st;
    } stage_dly_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dapuf_chain.sv
// One DAPUF delay chain: delay LFSR plus top/bottom path accumulators.
// Ports: clk, rst_n; i_init loads seed and start offset; i_step advances
// one stage using challenge bit i_c; o_top/o_bot are the path delays.
module dapuf_chain
    import dapuf_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int unsigned       DELAY_MIN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_init,
    input  logic [ACC_W-1:0] i_init_off,
    input  logic             i_step,
    input  logic             i_c,
    output logic [ACC_W-1:0] o_top,
    output logic [ACC_W-1:0] o_bot
);

    logic [LFSR_W-1:0] r_lfsr;
    logic [ACC_W-1:0]  r_top;
    logic [ACC_W-1:0]  r_bot;

    stage_dly_t        w_d;
    logic [ACC_W-1:0]  w_st;
    logic [ACC_W-1:0]  w_sb;
    logic [ACC_W-1:0]  w_xt;
    logic [ACC_W-1:0]  w_xb;

    assign w_d  = stage_dly_t'(r_lfsr);
    assign w_st = ACC_W'(w_d.d_st) + ACC_W'(DELAY_MIN);
    assign w_sb = ACC_W'(w_d.d_sb) + ACC_W'(DELAY_MIN);
    assign w_xt = ACC_W'(w_d.d_xt) + ACC_W'(DELAY_MIN);
    assign w_xb = ACC_W'(w_d.d_xb) + ACC_W'(DELAY_MIN);

    // Stage delays come from the current LFSR word; the LFSR then steps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
            r_top  <= '0;
            r_bot  <= '0;
        end else if (i_init) begin
            r_lfsr <= SEED;
            r_top  <= i_init_off;
            r_bot  <= i_init_off;
        end else if (i_step) begin
            r_lfsr <= lfsr_next(r_lfsr);
            if (i_c) begin
                r_top <= r_bot + w_xt;
                r_bot <= r_top + w_xb;
            end else begin
                r_top <= r_top + w_st;
                r_bot <= r_bot + w_sb;
            end
        end
    end

    assign o_top = r_top;
    assign o_bot = r_bot;

endmodule

// File: rtl/dapuf.sv
// Double Arbiter PUF top: launch edge detect, skew counter, FSM, two
// chains (L, R) and two cross arbiters whose decisions are XORed.
// Ports: clk, rst_n (async, active low), challenge, exciteL, exciteR,
// r1 (response), resp_valid (r1 holds a completed evaluation).
// Build option: DAPUF_NOISE_EN adds a free-running noise LFSR that
// decides arbiters whose inputs lie within NOISE_TH of each other.
module dapuf
    import dapuf_pkg::*;
#(
    parameter int unsigned       N_STAGES  = 64,
    parameter logic [LFSR_W-1:0] SEED_L    = 16'hACE1,
    parameter logic [LFSR_W-1:0] SEED_R    = 16'h1D2B,
    parameter int unsigned       DELAY_MIN = 4,
    parameter int unsigned       SKEW_UNIT = 8,
    parameter int unsigned       NOISE_TH  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_STAGES-1:0] challenge,
    input  logic                exciteL,
    input  logic                exciteR,
    output logic                r1,
    output logic                resp_valid
);

    localparam int unsigned STG_W = $clog2(N_STAGES);

    // Reject configurations whose accumulators could wrap
    if ((N_STAGES * (DELAY_MIN + 15) + 255 * SKEW_UNIT >= (1 << ACC_W)) ||
        (NOISE_TH >= (1 << ACC_W))) begin : g_cfg_err
        $error("dapuf: parameter set allows accumulator wrap");
    end

    state_t              r_state;
    logic                r_exc_l;
    logic                r_exc_l_d;
    logic                r_exc_r;
    logic                r_exc_r_d;
    logic                r_lf_l;
    logic                r_lf_r;
    logic [SKEW_W-1:0]   r_skew;
    logic [STG_W-1:0]    r_stage;
    logic [N_STAGES-1:0] r_chal;
    logic                r_r1;
    logic                r_resp_valid;

    logic                w_rise_l;
    logic                w_rise_r;
    logic                w_go_l;
    logic                w_go_r;
    logic                w_init;
    logic                w_step;
    logic [ACC_W-1:0]    w_skew_off;
    logic [ACC_W-1:0]    w_off_l;
    logic [ACC_W-1:0]    w_off_r;
    logic [ACC_W-1:0]    w_l_top;
    logic [ACC_W-1:0]    w_l_bot;
    logic [ACC_W-1:0]    w_r_top;
    logic [ACC_W-1:0]    w_r_bot;
    logic                w_arb_a;
    logic                w_arb_b;

    assign w_rise_l = r_exc_l & ~r_exc_l_d;
    assign w_rise_r = r_exc_r & ~r_exc_r_d;
    assign w_go_l   = r_lf_l | w_rise_l;
    assign w_go_r   = r_lf_r | w_rise_r;
    assign w_init   = (r_state == IDLE) && w_go_l && w_go_r;
    assign w_step   = (r_state == EVAL);

    // The side that launched first is early; the other chain starts late
    assign w_skew_off = ACC_W'(r_skew) * ACC_W'(SKEW_UNIT);
    assign w_off_l    = r_lf_r ? w_skew_off : '0;
    assign w_off_r    = r_lf_l ? w_skew_off : '0;

    dapuf_chain #(.SEED(SEED_L), .DELAY_MIN(DELAY_MIN)) u_chain_l (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_init     (w_init),
        .i_init_off (w_off_l),
        .i_step     (w_step),
        .i_c        (r_chal[r_stage]),
        .o_top      (w_l_top),
        .o_bot      (w_l_bot)
    );

    dapuf_chain #(.SEED(SEED_R), .DELAY_MIN(DELAY_MIN)) u_chain_r (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_init     (w_init),
        .i_init_off (w_off_r),
        .i_step     (w_step),
        .i_c        (r_chal[r_stage]),
        .o_top      (w_r_top),
        .o_bot      (w_r_bot)
    );

`ifdef DAPUF_NOISE_EN
    logic [LFSR_W-1:0] r_noise;
    logic [ACC_W-1:0]  w_diff_a;
    logic [ACC_W-1:0]  w_diff_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_noise <= 16'hBEEF;
        else        r_noise <= lfsr_next(r_noise);
    end

    assign w_diff_a = (w_l_top > w_r_top) ? (w_l_top - w_r_top) : (w_r_top - w_l_top);
    assign w_diff_b = (w_l_bot > w_r_bot) ? (w_l_bot - w_r_bot) : (w_r_bot - w_l_bot);
    // Near-ties model a metastable arbiter resolving randomly
    assign w_arb_a  = (w_diff_a <= ACC_W'(NOISE_TH)) ? r_noise[0] : (w_l_top < w_r_top);
    assign w_arb_b  = (w_diff_b <= ACC_W'(NOISE_TH)) ? r_noise[1] : (w_l_bot < w_r_bot);
`else
    assign w_arb_a  = (w_l_top < w_r_top);
    assign w_arb_b  = (w_l_bot < w_r_bot);
`endif

    // Edge history, launch bookkeeping and evaluation sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_exc_l      <= 1'b0;
            r_exc_l_d    <= 1'b0;
            r_exc_r      <= 1'b0;
            r_exc_r_d    <= 1'b0;
            r_lf_l       <= 1'b0;
            r_lf_r       <= 1'b0;
            r_skew       <= '0;
            r_stage      <= '0;
            r_chal       <= '0;
            r_r1         <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_exc_l   <= exciteL;
            r_exc_l_d <= r_exc_l;
            r_exc_r   <= exciteR;
            r_exc_r_d <= r_exc_r;
            unique case (r_state)
                IDLE: begin
                    if (w_go_l && w_go_r) begin
                        r_chal       <= challenge;
                        r_resp_valid <= 1'b0;
                        r_stage      <= '0;
                        r_lf_l       <= 1'b0;
                        r_lf_r       <= 1'b0;
                        r_state      <= EVAL;
                    end else begin
                        if (w_rise_l) r_lf_l <= 1'b1;
                        if (w_rise_r) r_lf_r <= 1'b1;
                        // Count from the first rise; the rise cycle itself counts as one
                        if ((w_go_l ^ w_go_r) && (r_skew != '1)) r_skew <= r_skew + 1'b1;
                    end
                end
                EVAL: begin
                    r_stage <= r_stage + 1'b1;
                    if (r_stage == STG_W'(N_STAGES - 1)) r_state <= RESOLVE;
                end
                RESOLVE: begin
                    r_r1         <= w_arb_a ^ w_arb_b;
                    r_resp_valid <= 1'b1;
                    r_state      <= REARM;
                end
                REARM: begin
                    if (!r_exc_l && !r_exc_r) begin
                        r_skew  <= '0;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign r1         = r_r1;
    assign resp_valid = r_resp_valid;

endmodule

// File: tb/tb_dapuf.sv
// Directed bench for dapuf: latency, response against a reference model,
// equal-seed tie/skew cases, skew saturation, ignored toggles and reset abort.
module tb_dapuf;

    localparam logic [15:0] SL = 16'hACE1;
    localparam logic [15:0] SR = 16'h1D2B;
    localparam logic [63:0] C1 = 64'h05050F0F05050F0F;
    localparam logic [63:0] C2 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C3 = 64'hDEADBEEF00C0FFEE;

    logic        clk;
    logic        rst_n;
    logic [63:0] challenge;
    logic        exciteL;
    logic        exciteR;
    logic        r1;
    logic        rv;
    logic        r1_eq;
    logic        rv_eq;

    int n_chk;
    int n_bad;
    int lat;
    logic first_r1;

    dapuf u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .challenge  (challenge),
        .exciteL    (exciteL),
        .exciteR    (exciteR),
        .r1         (r1),
        .resp_valid (rv)
    );

    dapuf #(.SEED_L(SL), .SEED_R(SL)) u_eq (
        .clk        (clk),
        .rst_n      (rst_n),
        .challenge  (challenge),
        .exciteL    (exciteL),
        .exciteR    (exciteR),
        .r1         (r1_eq),
        .resp_valid (rv_eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Independent reference: explicit-tap Fibonacci LFSR, integer path sums
    function automatic logic model_r1(input logic [15:0] sl0, input logic [15:0] sr0,
                                      input logic [63:0] ch, input int skew, input logic late_r);
        int lt, lb, rt, rb, nt, nb;
        logic [15:0] sl, sr;
        lt = 0; lb = 0; rt = 0; rb = 0;
        if (late_r) begin rt = skew * 8; rb = skew * 8; end
        else        begin lt = skew * 8; lb = skew * 8; end
        sl = sl0;
        sr = sr0;
        for (int i = 0; i < 64; i++) begin
            if (ch[i]) begin
                nt = lb + int'(sl[11:8]) + 4;  nb = lt + int'(sl[15:12]) + 4;  lt = nt; lb = nb;
                nt = rb + int'(sr[11:8]) + 4;  nb = rt + int'(sr[15:12]) + 4;  rt = nt; rb = nb;
            end else begin
                lt = lt + int'(sl[3:0]) + 4;   lb = lb + int'(sl[7:4]) + 4;
                rt = rt + int'(sr[3:0]) + 4;   rb = rb + int'(sr[7:4]) + 4;
            end
            sl = {sl[14:0], sl[15] ^ sl[13] ^ sl[12] ^ sl[10]};
            sr = {sr[14:0], sr[15] ^ sr[13] ^ sr[12] ^ sr[10]};
        end
        return (lt < rt) ^ (lb < rb);
    endfunction

    // Counts posedges after the edge that captures the second launch
    task automatic wait_resp(output int n);
        n = -1;
        @(posedge clk);
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (rv) begin
                n = k;
                break;
            end
        end
    endtask

    // gap=0: same-cycle launch; otherwise first side leads by gap cycles
    task automatic launch(input logic [63:0] ch, input int gap, input logic l_first);
        @(negedge clk);
        challenge = ch;
        if (gap == 0) begin
            exciteL = 1'b1;
            exciteR = 1'b1;
        end else begin
            if (l_first) exciteL = 1'b1; else exciteR = 1'b1;
            repeat (gap) @(negedge clk);
            exciteL = 1'b1;
            exciteR = 1'b1;
        end
    endtask

    task automatic drop();
        @(negedge clk);
        exciteL = 1'b0;
        exciteR = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic seen;
        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        exciteL = 1'b0;
        exciteR = 1'b0;
        challenge = '0;

        // Reset state and quiet idle
        repeat (3) @(negedge clk);
        chk("rst_r1", 32'(r1), 0);
        chk("rst_rv", 32'(rv), 0);
        chk("rst_rv_eq", 32'(rv_eq), 0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | r1 | rv | r1_eq | rv_eq;
        end
        chk("idle_quiet", 32'(seen), 0);

        // Simultaneous launch, reference model
        launch(C1, 0, 1'b1);
        wait_resp(lat);
        chk("lat_c1", 32'(lat), 66);
        chk("r1_c1", 32'(r1), 32'(model_r1(SL, SR, C1, 0, 1'b0)));
        chk("eq_c1_tie", 32'(r1_eq), 0);
        first_r1 = r1;
        drop();
        chk("rearm_hold_rv", 32'(rv), 1);

        // Repeatability, then all-ones challenge
        launch(C1, 0, 1'b1);
        wait_resp(lat);
        chk("lat_c1_again", 32'(lat), 66);
        chk("r1_c1_repeat", 32'(r1), 32'(first_r1));
        drop();
        launch(64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1);
        wait_resp(lat);
        chk("r1_ones", 32'(r1), 32'(model_r1(SL, SR, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0)));
        chk("eq_ones_tie", 32'(r1_eq), 0);
        drop();

        // Zero challenge: equal seeds tie on both arbiters
        launch(64'h0, 0, 1'b1);
        wait_resp(lat);
        chk("eq_zero_tie", 32'(r1_eq), 0);
        chk("r1_zero", 32'(r1), 32'(model_r1(SL, SR, 64'h0, 0, 1'b0)));
        drop();

        // L leads by 3: R starts 24 late, equal-seed arbiters both 1
        launch(C1, 3, 1'b1);
        wait_resp(lat);
        chk("lat_skew3", 32'(lat), 66);
        chk("skew3_cnt", 32'(u_eq.r_skew), 3);
        chk("eq_skew3", 32'(r1_eq), 0);
        chk("r1_skew3", 32'(r1), 32'(model_r1(SL, SR, C1, 3, 1'b1)));
        drop();

        // R leads by 5: L chain is late
        launch(C2, 5, 1'b0);
        wait_resp(lat);
        chk("r1_skew5_rfirst", 32'(r1), 32'(model_r1(SL, SR, C2, 5, 1'b0)));
        drop();

        // Skew saturation
        launch(C1, 300, 1'b1);
        wait_resp(lat);
        chk("lat_skew_sat", 32'(lat), 66);
        chk("skew_sat_cnt", 32'(u_eq.r_skew), 255);
        chk("eq_skew_sat", 32'(r1_eq), 0);
        chk("r1_skew_sat", 32'(r1), 32'(model_r1(SL, SR, C1, 255, 1'b1)));
        drop();

        // Toggles of exciteL and challenge during EVAL are ignored
        launch(C2, 0, 1'b1);
        fork
            wait_resp(lat);
            begin
                repeat (10) @(negedge clk);
                exciteL = 1'b0;
                challenge = ~C2;
                repeat (2) @(negedge clk);
                exciteL = 1'b1;
            end
        join
        chk("lat_toggle", 32'(lat), 66);
        chk("r1_toggle", 32'(r1), 32'(model_r1(SL, SR, C2, 0, 1'b0)));
        drop();

        // Reset mid-EVAL aborts; the next launch is normal
        launch(C3, 0, 1'b1);
        repeat ($urandom_range(3, 50)) @(negedge clk);
        rst_n = 1'b0;
        exciteL = 1'b0;
        exciteR = 1'b0;
        #1;
        chk("abort_r1", 32'(r1), 0);
        chk("abort_rv", 32'(rv), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("abort_no_resp", 32'(rv), 0);
        launch(C3, 0, 1'b1);
        wait_resp(lat);
        chk("lat_after_abort", 32'(lat), 66);
        chk("r1_after_abort", 32'(r1), 32'(model_r1(SL, SR, C3, 0, 1'b0)));
        drop();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
